// File: rtl/pipe_stage_skid.sv
// Two-entry pipeline stage (main + skid). Load-to-output latency is 1 cycle; streams 1 entry/cycle.
// in_ready depends only on registered state (skid empty); out_ready stalls the head, which holds stable.
module pipe_stage_skid #(
    parameter int            IW       = 8,
    parameter int            AW       = 8,
    parameter logic [IW-1:0] NOP_INST = '0
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] in_inst,
    input  logic [AW-1:0] in_pc1,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [IW-1:0] out_inst,
    output logic [AW-1:0] out_pc1,
    output logic [1:0]    count
);

    typedef struct packed {
        logic [IW-1:0] inst;
        logic [AW-1:0] pc1;
    } entry_t;

    entry_t main_dat;
    entry_t skid_dat;
    entry_t in_dat;
    logic   main_vld;
    logic   skid_vld;
    logic   accept;
    logic   drain;

    assign in_dat   = '{inst: in_inst, pc1: in_pc1};
    assign in_ready = !skid_vld;
    assign accept   = in_valid && in_ready;
    assign drain    = main_vld && out_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            main_dat <= '0;
            skid_dat <= '0;
        end else if (flush) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
        end else if (skid_vld) begin
            // in_ready is low here, so only a drain can move state
            if (drain) begin
                main_dat <= skid_dat;
                skid_vld <= 1'b0;
            end
        end else if (main_vld) begin
            if (accept && drain) begin
                main_dat <= in_dat;
            end else if (accept) begin
                skid_dat <= in_dat;
                skid_vld <= 1'b1;
            end else if (drain) begin
                main_vld <= 1'b0;
            end
        end else if (accept) begin
            main_dat <= in_dat;
            main_vld <= 1'b1;
        end
    end

    // Bubble is forced from the valid bit so reset/flush show NOP without waiting on data regs
    assign out_valid = main_vld;
    assign out_inst  = main_vld ? main_dat.inst : NOP_INST;
    assign out_pc1   = main_vld ? main_dat.pc1 : '0;
    assign count     = {1'b0, main_vld} + {1'b0, skid_vld};

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameters SHALL be as follows, one per line (name, default, meaning):
- IW, 8, instruction field width in bits.
- AW, 8, PC+1 field width in bits.
- NOP_INST, 0 (IW bits), bubble instruction value.
REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- clock, in, 1, single clock; all state updates on rising edge.
- reset_n, in, 1, asynchronous active-low reset.
- flush, in, 1, synchronous squash of all held entries.
- in_valid, in, 1, upstream offers an entry.
- in_ready, out, 1, stage can accept an entry this cycle.
- in_inst, in, IW, offered instruction.
- in_pc1, in, AW, offered PC+1.
- out_valid, out, 1, head entry present.
- out_ready, in, 1, downstream takes the head entry this cycle.
- out_inst, out, IW, head instruction.
- out_pc1, out, AW, head PC+1.
- count, out, 2, number of held entries (0..2).

Function
REQ-003 Storage SHALL be a main register (drives out_*) and one skid register, each with its own valid bit; skid valid SHALL imply main valid.
REQ-004 An accept SHALL occur when in_valid && in_ready at a rising edge; a drain SHALL occur when out_valid && out_ready at a rising edge.
REQ-005 in_ready SHALL equal !skid_valid, a function of registered state only, with no combinational path from out_ready or in_valid.
REQ-006 Accept into empty stage: main loads input; out_valid asserts the next cycle (1-cycle latency).
REQ-007 Accept with main valid and drain in the same cycle, skid empty: main loads input; count stays 1.
REQ-008 Accept with main valid and no drain: skid loads input; count becomes 2; in_ready deasserts the next cycle.
REQ-009 Drain with skid valid: main loads skid contents and skid clears in the same edge; count becomes 1.
REQ-010 Drain with skid empty and no accept: main valid clears; count becomes 0.
REQ-011 Entries SHALL leave in acceptance order; none SHALL be duplicated or dropped except by flush.
REQ-012 Sustained throughput SHALL be one entry per cycle when out_ready is held high.
REQ-013 Whenever out_valid is 0, out_inst SHALL be NOP_INST and out_pc1 SHALL be 0 (bubble).
REQ-014 While out_valid=1 and out_ready=0, out_inst and out_pc1 SHALL be held stable.
REQ-015 flush SHALL take priority over every other event in the same cycle: both valid bits clear, out_* become bubble, and any concurrent accept is discarded.
REQ-016 flush SHALL NOT gate in_ready combinationally; in_ready is 1 in the cycle after a flush.
REQ-017 count SHALL equal main_valid + skid_valid.

Reset
REQ-018 On reset_n low, the stage SHALL immediately (without a clock edge) set both valid bits to 0, out_inst to NOP_INST, out_pc1 to 0, count to 0 and in_ready to 1.
REQ-019 Reset asserted mid-operation SHALL discard all held entries.
REQ-020 Release of reset_n SHALL take effect at the first rising edge after deassertion; no accept SHALL occur while reset_n is low.

Verification
REQ-021 Benches SHALL cover the following directed scenarios:
- Single entry: reset, accept inst=0x3C pc1=0x05, out_ready=1 -> next cycle out_valid=1, out_inst=0x3C, out_pc1=0x05; following cycle out_valid=0, out_inst=NOP_INST.
- Backpressure: out_ready=0, offer 0x11, 0x22, 0x33 on consecutive cycles -> 0x11, 0x22 accepted, count=2, in_ready=0; 0x33 held upstream; raise out_ready -> 0x11, 0x22, 0x33 emerge in order.
- Streaming: 16 back-to-back entries 0x00..0x0F with out_ready=1 -> one output per cycle, count never exceeds 1.
- Flush collision: count=2, flush=1 with in_valid=1 (0x44) -> next cycle count=0, out_valid=0, out_inst=NOP_INST, out_pc1=0; 0x44 never appears.
- Async reset: count=2, pulse reset_n low between edges -> outputs go to bubble and count=0 before the next edge.
- Stability: out_valid=1 with out_ready=0 for 5 cycles while the input toggles -> out_inst and out_pc1 unchanged.
